// File: rtl/round_constant_lfsr_gen.sv
// Keccak-p iota round-constant generator driven by the rc(t) LFSR, one round per advance.
// Generalised over lane width W and round count NR; the start seed is folded at elaboration.
module round_constant_lfsr_gen #(
    parameter int unsigned W  = 64,
    parameter int unsigned NR = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic         advance_i,
    output logic [W-1:0] round_constant_o,
    output logic [4:0]   round_idx_o,
    output logic         valid_o,
    output logic         last_round_o,
    output logic         done_o
);

    localparam int unsigned L     = $clog2(W);
    localparam int unsigned NRMAX = 12 + 2 * L;
    localparam int unsigned IR0   = NRMAX - NR;
    localparam logic [4:0]  IR0_V  = 5'(IR0);
    localparam logic [4:0]  LAST_V = 5'(NRMAX - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    if (W > 64 || (32'd1 << L) != W || NR < 1 || NR > NRMAX) begin : g_param_err
        $error("round_constant_lfsr_gen: illegal W=%0d / NR=%0d", W, NR);
    end

    function automatic logic [7:0] lfsr_step(input logic [7:0] r);
        logic [8:0] s;
        s = {r, 1'b0};
        // Feedback from the shifted-out bit 8 into taps 0, 4, 5, 6.
        if (s[8]) s = s ^ 9'h071;
        return s[7:0];
    endfunction

    function automatic logic [7:0] lfsr_step7(input logic [7:0] r);
        logic [7:0] x;
        x = r;
        for (int i = 0; i < 7; i++) x = lfsr_step(x);
        return x;
    endfunction

    function automatic logic [7:0] seed_calc(input int unsigned ir0);
        logic [7:0] x;
        x = 8'h01;
        for (int unsigned t = 0; t < (7 * ir0) % 255; t++) x = lfsr_step(x);
        return x;
    endfunction

    localparam logic [7:0] SEED = seed_calc(IR0);

    logic [0:0]   r_state;
    logic [7:0]   r_lfsr;
    logic [4:0]   r_ir;
    logic         r_done;
    logic         w_valid;
    logic         w_last;
    logic [7:0]   w_chain [L+1];
    logic [W-1:0] w_rc;

    assign w_valid = (r_state == ST_RUN);
    assign w_last  = w_valid && (r_ir == LAST_V);

    // Unrolled look-ahead: w_chain[j] is the LFSR state at t = 7*ir + j.
    assign w_chain[0] = r_lfsr;
    for (genvar j = 1; j <= L; j++) begin : g_chain
        assign w_chain[j] = lfsr_step(w_chain[j-1]);
    end

    for (genvar b = 0; b < W; b++) begin : g_bit
        if (((b + 1) & b) == 0) begin : g_tap
            assign w_rc[b] = w_chain[$clog2(b + 1)][0];
        end else begin : g_zero
            assign w_rc[b] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_lfsr  <= 8'h01;
            r_ir    <= 5'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start_i) begin
                r_state <= ST_RUN;
                r_lfsr  <= SEED;
                r_ir    <= IR0_V;
            end else if (advance_i && w_valid) begin
                if (w_last) begin
                    r_state <= ST_IDLE;
                    r_lfsr  <= 8'h01;
                    r_ir    <= 5'd0;
                    r_done  <= 1'b1;
                end else begin
                    r_lfsr <= lfsr_step7(r_lfsr);
                    r_ir   <= r_ir + 5'd1;
                end
            end
        end
    end

    assign round_constant_o = w_valid ? w_rc : '0;
    assign round_idx_o      = w_valid ? r_ir : 5'd0;
    assign valid_o          = w_valid;
    assign last_round_o     = w_last;
    assign done_o           = r_done;

endmodule
